// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: redirect input, instruction-memory request/ack channel and
// the fetch-to-decode queue head handshake.
interface pc_fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        fd_valid;
    logic        fd_ready;
    logic [31:0] fd_instr;
    logic [31:0] fd_pc;
    logic [31:0] fd_pc_plus4;

    modport master (
        input  redirect_valid, redirect_target, imem_ack, imem_rdata, fd_ready,
        output imem_req, imem_addr, fd_valid, fd_instr, fd_pc, fd_pc_plus4
    );

    modport slave (
        output redirect_valid, redirect_target, imem_ack, imem_rdata, fd_ready,
        input  imem_req, imem_addr, fd_valid, fd_instr, fd_pc, fd_pc_plus4
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: one outstanding instruction-memory request,
// small fetch queue to decode, redirect flushes queue and in-flight data.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    pc_fetch_unit_if.master    bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_req_addr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [31:0]   r_q_instr [DEPTH];
    logic [31:0]   r_q_pc    [DEPTH];
    logic [31:0]   r_q_pc4   [DEPTH];

    logic          w_push;
    logic          w_pop;
    logic          w_load_req;
    logic [31:0]   w_req_plus4;

    assign w_req_plus4 = r_req_addr + 32'd4;

    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_load_req   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!bus.redirect_valid && (r_count < FULL)) begin
                    w_next_state = FETCH;
                    w_load_req   = 1'b1;
                end
            end
            FETCH: begin
                if (bus.redirect_valid) begin
                    w_next_state = bus.imem_ack ? IDLE : FLUSH;
                end else if (bus.imem_ack) begin
                    w_push       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            FLUSH: begin
                // Wrong-path response is consumed and dropped here.
                if (bus.imem_ack) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_pop = (r_count != '0) && bus.fd_ready && !bus.redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
                r_q_pc4[i]   <= '0;
            end
        end else begin
            r_state <= w_next_state;
            if (w_load_req) r_req_addr <= r_pc;

            if (bus.redirect_valid) begin
                r_pc    <= bus.redirect_target;
                r_count <= '0;
                r_head  <= '0;
                r_tail  <= '0;
            end else begin
                if (w_push) begin
                    r_pc              <= w_req_plus4;
                    r_q_instr[r_tail] <= bus.imem_rdata;
                    r_q_pc[r_tail]    <= r_req_addr;
                    r_q_pc4[r_tail]   <= w_req_plus4;
                    r_tail            <= r_tail + AW'(1);
                end
                if (w_pop) r_head <= r_head + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign bus.imem_req    = (r_state != IDLE);
    assign bus.imem_addr   = r_req_addr;
    assign bus.fd_valid    = (r_count != '0);
    assign bus.fd_instr    = r_q_instr[r_head];
    assign bus.fd_pc       = r_q_pc[r_head];
    assign bus.fd_pc_plus4 = r_q_pc4[r_head];
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, streaming fetch, full queue,
// redirects with pending/simultaneous ack, PC wrap and reset mid-request.
module tb_pc_fetch_unit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.imem_ack        = 1'b0;
        bus.imem_rdata      = '0;
        bus.fd_ready        = 1'b0;
    endtask

    // Leaves the DUT in FETCH with the first request to RESET_PC.
    task automatic reset_dut();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk("rst_req",   {31'b0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'b0, bus.fd_valid}, 32'd0);
        chk("rst_pc",    bus.fd_pc,       32'd0);
        chk("rst_instr", bus.fd_instr,    32'd0);
        chk("rst_pc4",   bus.fd_pc_plus4, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("boot_req",  {31'b0, bus.imem_req}, 32'd1);
        chk("boot_addr", bus.imem_addr, 32'h0000_0000);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        reset_dut();

        // Streaming fetch, decode always ready
        bus.fd_ready = 1'b1;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hA000_0000;
        tick();
        bus.imem_ack = 1'b0;
        chk("s0_valid", {31'b0, bus.fd_valid}, 32'd1);
        chk("s0_pc",    bus.fd_pc,       32'h0);
        chk("s0_pc4",   bus.fd_pc_plus4, 32'h4);
        chk("s0_instr", bus.fd_instr,    32'hA000_0000);
        tick();
        chk("s1_addr",  bus.imem_addr, 32'h4);
        chk("s1_valid", {31'b0, bus.fd_valid}, 32'd0);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hA000_0001;
        tick();
        bus.imem_ack = 1'b0;
        chk("s1_pc",    bus.fd_pc,    32'h4);
        chk("s1_instr", bus.fd_instr, 32'hA000_0001);
        tick();
        chk("s2_addr", bus.imem_addr, 32'h8);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hA000_0002;
        tick();
        bus.imem_ack = 1'b0;
        chk("s2_pc",  bus.fd_pc,       32'h8);
        chk("s2_pc4", bus.fd_pc_plus4, 32'hC);

        // Decode stalled: queue fills with 0x0 and 0x4, requests stop
        reset_dut();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hB000_0000;
        tick();
        bus.imem_ack = 1'b0;
        chk("f0_req", {31'b0, bus.imem_req}, 32'd0);
        tick();
        chk("f1_addr", bus.imem_addr, 32'h4);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hB000_0001;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        chk("full_req",   {31'b0, bus.imem_req}, 32'd0);
        chk("full_valid", {31'b0, bus.fd_valid}, 32'd1);
        chk("full_pc",    bus.fd_pc,    32'h0);
        chk("full_instr", bus.fd_instr, 32'hB000_0000);
        tick();
        chk("full_req2", {31'b0, bus.imem_req}, 32'd0);
        bus.fd_ready = 1'b1;
        tick();
        bus.fd_ready = 1'b0;
        chk("pop_pc",    bus.fd_pc,    32'h4);
        chk("pop_instr", bus.fd_instr, 32'hB000_0001);
        chk("pop_req",   {31'b0, bus.imem_req}, 32'd0);
        tick();
        chk("refill_req",  {31'b0, bus.imem_req}, 32'd1);
        chk("refill_addr", bus.imem_addr, 32'h8);

        // Redirect to 0x100 with request to 0x8 still pending
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        chk("fl0_req",   {31'b0, bus.imem_req}, 32'd1);
        chk("fl0_addr",  bus.imem_addr, 32'h8);
        chk("fl0_valid", {31'b0, bus.fd_valid}, 32'd0);
        tick();
        chk("fl1_addr", bus.imem_addr, 32'h8);
        tick();
        chk("fl2_addr", bus.imem_addr, 32'h8);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_ack = 1'b0;
        chk("fl_drop_valid", {31'b0, bus.fd_valid}, 32'd0);
        tick();
        chk("fl_new_addr",  bus.imem_addr, 32'h100);
        chk("fl_new_valid", {31'b0, bus.fd_valid}, 32'd0);

        // Redirect coinciding with ack
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'h200;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_0000;
        tick();
        clear_inputs();
        chk("ra_valid", {31'b0, bus.fd_valid}, 32'd0);
        tick();
        chk("ra_addr", bus.imem_addr, 32'h200);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hC000_0200;
        tick();
        bus.imem_ack = 1'b0;
        chk("ra_pc",    bus.fd_pc,    32'h200);
        chk("ra_instr", bus.fd_instr, 32'hC000_0200);

        // Redirect in IDLE to top of address space, PC+4 wraps
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        chk("w_flush_valid", {31'b0, bus.fd_valid}, 32'd0);
        tick();
        chk("w_addr", bus.imem_addr, 32'hFFFF_FFFC);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hE000_0000;
        tick();
        bus.imem_ack = 1'b0;
        chk("w_pc",  bus.fd_pc,       32'hFFFF_FFFC);
        chk("w_pc4", bus.fd_pc_plus4, 32'h0);
        bus.fd_ready = 1'b1;
        tick();
        bus.fd_ready = 1'b0;
        chk("w_next_addr", bus.imem_addr, 32'h0);
        chk("w_next_req",  {31'b0, bus.imem_req}, 32'd1);

        // Reset asserted with a request outstanding and queue non-empty
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hF000_0000;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        chk("mr_pre_req",   {31'b0, bus.imem_req}, 32'd1);
        chk("mr_pre_valid", {31'b0, bus.fd_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_req",   {31'b0, bus.imem_req}, 32'd0);
        chk("mr_valid", {31'b0, bus.fd_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h57A1_E000;
        tick();
        bus.imem_ack = 1'b0;
        chk("mr_stale_valid", {31'b0, bus.fd_valid}, 32'd0);
        chk("mr_restart",     bus.imem_addr, 32'h0);
        chk("mr_restart_req", {31'b0, bus.imem_req}, 32'd1);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
        tick();
        bus.imem_ack = 1'b0;
        chk("mr_pc",    bus.fd_pc,    32'h0);
        chk("mr_instr", bus.fd_instr, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, fetch-queue entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port redirect_valid  input  1  taken branch/jump from branch-target stage.
REQ-006 SHALL have port redirect_target  input  32  redirect PC (branch_address_cal_out of downstream target adder).
REQ-007 SHALL have port imem_req  output  1  instruction-memory request.
REQ-008 SHALL have port imem_addr  output  32  request address.
REQ-009 SHALL have port imem_ack  input  1  request completed, imem_rdata valid this cycle.
REQ-010 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-011 SHALL have port fd_valid  output  1  queue head valid to decode.
REQ-012 SHALL have port fd_ready  input  1  decode accepts head.
REQ-013 SHALL have ports fd_instr, fd_pc, fd_pc_plus4  output  32 each  head instruction, its PC, PC+4 (pc_value feed to target adder).

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, FLUSH; at most one memory request outstanding.
REQ-015 SHALL drive imem_req=1 in FETCH and FLUSH, 0 in IDLE.
REQ-016 SHALL hold imem_addr constant from req assertion until the ack cycle, via a req_addr register separate from pc.
REQ-017 SHALL, IDLE: go FETCH next cycle with req_addr<=pc when count<DEPTH, else stay IDLE.
REQ-018 SHALL, FETCH with imem_ack and no redirect: push {imem_rdata, req_addr, req_addr+4}, pc<=req_addr+4, go IDLE.
REQ-019 SHALL enter FETCH only with a free slot (one outstanding request max), so an ack push never overflows.
REQ-020 SHALL pop head when fd_valid & fd_ready & !redirect_valid; push and pop in one cycle leave count unchanged.
REQ-021 SHALL drive fd_valid=(count!=0), fd_* from head entry; head/tail pointers wrap modulo DEPTH.
REQ-022 SHALL, on redirect_valid in any state: count<=0, pointers reset, pc<=redirect_target, pop suppressed.
REQ-023 SHALL, redirect in IDLE: go IDLE (refetch at target next cycle per REQ-017).
REQ-024 SHALL, redirect in FETCH with imem_ack same cycle: discard rdata, go IDLE.
REQ-025 SHALL, redirect in FETCH without imem_ack: go FLUSH, keep req and req_addr.
REQ-026 SHALL, FLUSH: on imem_ack discard rdata, go IDLE; a further redirect in FLUSH only updates pc.
REQ-027 SHALL compute PC+4 mod 2^32 (0xFFFF_FFFC wraps to 0x0000_0000); no misalignment check.
REQ-028 SHALL give priority redirect > ack push > pop.

Reset
REQ-029 SHALL on rst_n low immediately set state=IDLE, pc=RESET_PC, req_addr=RESET_PC, count=0, pointers=0.
REQ-030 SHALL hold imem_req=0, fd_valid=0 while reset asserted; fd_instr/fd_pc/fd_pc_plus4 reset to 0.
REQ-031 SHALL, on reset mid-request, drop the request; a later stale imem_ack in IDLE is ignored.
REQ-032 SHALL assert first imem_req with imem_addr=RESET_PC one cycle after rst_n release.

Verification
REQ-033 SHALL cover reset release, ack 1 cycle after each req, fd_ready=1 -> fd_pc 0x0,0x4,0x8 in order, fd_pc_plus4=fd_pc+4.
REQ-034 SHALL cover fd_ready=0, acks immediate -> two entries (0x0,0x4) queued, fd_valid=1, imem_req stays 0 until one pop.
REQ-035 SHALL cover redirect_target=0x100 while request to 0x8 outstanding, ack 3 cycles later -> imem_addr held 0x8 until ack, data dropped, next req addr 0x100, fd_valid=0 meanwhile.
REQ-036 SHALL cover redirect and imem_ack same cycle -> ack data not enqueued, next fd_pc=0x200 for target 0x200.
REQ-037 SHALL cover pc=0xFFFF_FFFC fetch -> fd_pc_plus4=0x0, next req addr 0x0.
REQ-038 SHALL cover rst_n low during outstanding request -> imem_req=0 and fd_valid=0 same cycle, restart at RESET_PC.
